zephyr_cpu: RTL and testbench
=============================

Name: zephyr_cpu

Overview:
- Minimal 8-bit multi-cycle accumulator-style CPU: 4-bit PC, 16x8 unified program/data RAM, 4x8 register file, 8-bit ALU.
- Self-contained top of the zephyr design; its only ports are clock and reset.
- Benches preload and inspect state through fixed hierarchical names, so those names are part of the interface.

Parameters:
- None. All widths are fixed: data 8, address 4, register index 2, state 4.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  reset; one clock; asynchronous and active-low (RESET=0 resets immediately, independent of CLK).

Behaviour:
- Required internal names, visible to benches:
  - PC[3:0]; IR[7:0]; RAM_ADDR[3:0]; zstate[3:0].
  - Instance ram_inst with array registers[0:15] of 8 bits.
  - Instance register_file with array registers[0:3] of 8 bits.
- Reset:
  - PC=0, IR=0, RAM_ADDR=0, zstate=FETCH, all four register_file entries=0, internal MDR/A/B/ALU result=0.
  - RAM contents are NOT cleared, so preloads survive reset.
- RAM: asynchronous read of registers[RAM_ADDR]; synchronous write.
- Instruction format:
  - [7:6] opcode; [5:4] Rd (register); [3:0] address.
  - For ALU ops: [3:2] alu_op and [1:0] Rs.
- Opcodes:
  - 00 NOP.
  - 01 LOAD Rd <- mem[addr].
  - 10 STR mem[addr] <- Rd.
  - 11 ALU Rd <- Rd op Rs.
- ALU ops: 00 ADD, 01 SUB (Rd-Rs), 10 AND, 11 OR.
  - Results truncated to 8 bits; carry/borrow discarded; no flags.
- States (zstate encoding):
  - FETCH=0, DECODE=1, EXECUTE=2, FETCH_DATA_B=3, ALU_EXECUTE=4, ALU_WRITEBK=5, MEMREAD=6, MEMWRITE=7, REGWRITE=8.
- Transitions, one state per clock:
  - FETCH: IR<=mem[PC], PC<=PC+1 (4-bit wrap 15->0) -> DECODE.
  - DECODE: RAM_ADDR<=IR[3:0] -> EXECUTE.
  - EXECUTE: dispatch on opcode. NOP -> FETCH; LOAD -> MEMREAD; STR -> MEMWRITE; ALU -> FETCH_DATA_B.
  - MEMREAD: MDR<=mem[RAM_ADDR] -> REGWRITE.
  - REGWRITE: R[Rd]<=MDR -> FETCH.
  - MEMWRITE: mem[RAM_ADDR]<=R[Rd] -> FETCH.
  - FETCH_DATA_B: A<=R[Rd], B<=R[Rs] -> ALU_EXECUTE.
  - ALU_EXECUTE: result<=A op B -> ALU_WRITEBK.
  - ALU_WRITEBK: R[Rd]<=result -> FETCH.
  - Any unlisted zstate value -> FETCH.
- During FETCH, RAM_ADDR<=PC. This makes RAM_ADDR track the PC in fetch and the operand address from DECODE onward.
- Latency in clocks: NOP 3, STR 4, LOAD 5, ALU 6.
- Self-modifying code is allowed: STR to an address later fetched executes the stored byte.
- When Rd==Rs, an ALU op uses the same value for both operands (e.g. SUB gives 0).
- Reset asserted mid-instruction aborts it immediately. No partial register or RAM write may complete after RESET falls.

Optional Feature:
- Macro ZEPHYR_HALT_EN.
- Defined:
  - Instruction 0x0F is HALT. EXECUTE goes to state HALT=9 (4'b1001).
  - In HALT, the CPU stays there forever: PC, registers and RAM are frozen. Only reset leaves HALT.
- Undefined: 0x0F is an ordinary NOP, and encoding 9 is unused (treated as unlisted -> FETCH).

Test Plan:
- Reset: preload RAM, then release RESET. Required: PC=0, zstate=0, R0..R3=0, and RAM unchanged.
- Program RAM[0..2]=4E,5F,C1 with RAM[14]=02, RAM[15]=05, run 16 clocks.
  - Required: R0=07, R1=05, PC=3, zstate=FETCH.
  - After the second LOAD completes (clock 10), R0=02.
- STR: RAM[0]=4E, RAM[1]=8D, RAM[14]=A5, run 9 clocks. Required: RAM[13]=A5.
- ALU wrap and ops: R0=02, R1=05 via loads, then execute each of the following in turn, reloading the operands before each op.
  - C5 (SUB): R0=FD.
  - C9 (AND): R0=00.
  - CD (OR): R0=07.
  - 0xC0 with R0=80 (ADD R0,R0): R0=00.
- PC wrap: all-NOP RAM, 48 clocks. Required: PC goes 15->0 at the 16th fetch, and the next fetch reads RAM[0].
- Reset mid-ALU: pull RESET low during ALU_EXECUTE. Required: R0 is 0 immediately and no writeback occurs. With ZEPHYR_HALT_EN, RAM[3]=0F: zstate holds 9 and PC holds 4 indefinitely.

Source files
------------

// File: rtl/zephyr_cpu.sv
// zephyr_cpu: 8-bit multi-cycle accumulator CPU with 16x8 unified RAM and 4x8 register file.
// Define ZEPHYR_HALT_EN to make instruction 0x0F a permanent HALT.
module zephyr_ram (
  input  logic       CLK,
  input  logic       we,
  input  logic [3:0] raddr,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  logic [7:0] registers [0:15];
  assign rdata = registers[raddr];
  always_ff @(posedge CLK)
    if (we) registers[waddr] <= wdata;
endmodule

module zephyr_regfile (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  input  logic [1:0] raddr_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b
);
  logic [7:0] registers [0:3];
  assign rdata_a = registers[raddr_a];
  assign rdata_b = registers[raddr_b];
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      for (int i = 0; i < 4; i++) registers[i] <= '0;
    end else if (we) registers[waddr] <= wdata;
endmodule

module zephyr_cpu (
  input logic CLK,
  input logic RESET
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXECUTE = 4'd2, FETCH_DATA_B = 4'd3, ALU_EXECUTE = 4'd4,
    ALU_WRITEBK = 4'd5, MEMREAD = 4'd6, MEMWRITE = 4'd7, REGWRITE = 4'd8, HALT = 4'd9
  } state_t;
  state_t zstate, zstate_nxt;
  logic [3:0] PC, RAM_ADDR, mem_raddr;
  logic [7:0] IR, MDR, A, B, ALU_RESULT, alu_y, mem_rdata, rd_data, rs_data, reg_wdata;
  logic mem_we, reg_we;
  // Instruction fetch reads at PC; every other access uses the latched operand address.
  assign mem_raddr = zstate == FETCH ? PC : RAM_ADDR;
  assign mem_we    = zstate == MEMWRITE;
  assign reg_we    = zstate == REGWRITE || zstate == ALU_WRITEBK;
  assign reg_wdata = zstate == REGWRITE ? MDR : ALU_RESULT;
  assign alu_y = IR[3:2] == 2'b00 ? A + B :
                 IR[3:2] == 2'b01 ? A - B :
                 IR[3:2] == 2'b10 ? A & B : A | B;
  zephyr_ram ram_inst (
    .CLK(CLK), .we(mem_we), .raddr(mem_raddr), .waddr(RAM_ADDR), .wdata(rd_data), .rdata(mem_rdata)
  );
  zephyr_regfile register_file (
    .CLK(CLK), .RESET(RESET), .we(reg_we), .waddr(IR[5:4]), .wdata(reg_wdata),
    .raddr_a(IR[5:4]), .raddr_b(IR[1:0]), .rdata_a(rd_data), .rdata_b(rs_data)
  );
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      PC         <= '0;
      IR         <= '0;
      RAM_ADDR   <= '0;
      zstate     <= FETCH;
      MDR        <= '0;
      A          <= '0;
      B          <= '0;
      ALU_RESULT <= '0;
    end else begin
      zstate <= zstate_nxt;
      if (zstate == FETCH) begin
        IR       <= mem_rdata;
        PC       <= PC + 4'd1;
        RAM_ADDR <= PC;
      end
      if (zstate == DECODE) RAM_ADDR <= IR[3:0];
      if (zstate == MEMREAD) MDR <= mem_rdata;
      if (zstate == FETCH_DATA_B) begin
        A <= rd_data;
        B <= rs_data;
      end
      if (zstate == ALU_EXECUTE) ALU_RESULT <= alu_y;
    end
  always_comb begin
    zstate_nxt = FETCH;
    case (zstate)
      FETCH:        zstate_nxt = DECODE;
      DECODE:       zstate_nxt = EXECUTE;
      EXECUTE: begin
        zstate_nxt = IR[7:6] == 2'b01 ? MEMREAD :
                     IR[7:6] == 2'b10 ? MEMWRITE :
                     IR[7:6] == 2'b11 ? FETCH_DATA_B : FETCH;
`ifdef ZEPHYR_HALT_EN
        if (IR == 8'h0F) zstate_nxt = HALT;
`endif
      end
      FETCH_DATA_B: zstate_nxt = ALU_EXECUTE;
      ALU_EXECUTE:  zstate_nxt = ALU_WRITEBK;
      MEMREAD:      zstate_nxt = REGWRITE;
`ifdef ZEPHYR_HALT_EN
      HALT:         zstate_nxt = HALT;
`endif
      default:      zstate_nxt = FETCH;
    endcase
  end
endmodule

// File: tb/tb_zephyr_cpu.sv
// tb_zephyr_cpu: ISA-level reference model feeds a retirement scoreboard for zephyr_cpu.
module tb_zephyr_cpu;
  logic CLK = 0;
  logic RESET = 0;
  always #5 CLK = ~CLK;

  zephyr_cpu dut (.CLK(CLK), .RESET(RESET));

  typedef struct packed {
    logic [3:0]   pc;
    logic [7:0]   ir;
    logic [31:0]  regs;
    logic [127:0] mem;
    logic [2:0]   lat;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  logic [7:0] init_mem [16];
  logic [7:0] m_mem [16];
  logic [7:0] m_r [4];
  logic [3:0] m_pc;
  bit halted;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pack_m();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = m_mem[i];
    return v;
  endfunction

  function automatic logic [127:0] dut_mem();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = dut.ram_inst.registers[i];
    return v;
  endfunction

  function automatic logic [31:0] dut_regs();
    return {dut.register_file.registers[3], dut.register_file.registers[2],
            dut.register_file.registers[1], dut.register_file.registers[0]};
  endfunction

  // One architectural instruction; pushes the state expected when it retires.
  function automatic void model_step();
    logic [7:0] ir, a, b, y;
    logic [1:0] rd, op;
    exp_t e;
    ir = m_mem[m_pc];
    m_pc = m_pc + 4'd1;
`ifdef ZEPHYR_HALT_EN
    if (ir == 8'h0F) begin
      halted = 1;
      return;
    end
`endif
    op = ir[7:6];
    rd = ir[5:4];
    a = m_r[rd];
    b = m_r[ir[1:0]];
    case (ir[3:2])
      2'd0: y = a + b;
      2'd1: y = a - b;
      2'd2: y = a & b;
      default: y = a | b;
    endcase
    if (op == 2'd1) m_r[rd] = m_mem[ir[3:0]];
    if (op == 2'd2) m_mem[ir[3:0]] = m_r[rd];
    if (op == 2'd3) m_r[rd] = y;
    e.pc = m_pc;
    e.ir = ir;
    e.regs = {m_r[3], m_r[2], m_r[1], m_r[0]};
    e.mem = pack_m();
    e.lat = op == 2'd0 ? 3'd3 : op == 2'd2 ? 3'd4 : op == 2'd1 ? 3'd5 : 3'd6;
    q.push_back(e);
  endfunction

  // Monitor: an instruction retires when the CPU re-enters FETCH.
  int cnt = 0;
  logic [3:0] prev = 0;
  always @(negedge CLK) begin
    exp_t e;
    if (!mon_en) cnt = 0;
    else begin
      cnt++;
      if (dut.zstate == 4'd0 && prev != 4'd0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire actual=pc%0h required=none at %0t", dut.PC, $time);
        end else begin
          e = q.pop_front();
          chk("ret_pc", dut.PC, e.pc);
          chk("ret_ir", dut.IR, e.ir);
          chk("ret_regs", dut_regs(), e.regs);
          chk("ret_mem", dut_mem(), e.mem);
          chk("ret_latency", cnt, e.lat);
        end
        cnt = 0;
      end
    end
    prev = dut.zstate;
  end

  task automatic step_clk(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic run(input int k);
    RESET = 0;
    mon_en = 0;
    #1;
    for (int i = 0; i < 16; i++) begin
      dut.ram_inst.registers[i] = init_mem[i];
      m_mem[i] = init_mem[i];
    end
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_pc = 0;
    halted = 0;
    #1;
    chk("rst_pc", dut.PC, 0);
    chk("rst_zstate", dut.zstate, 0);
    chk("rst_ir", dut.IR, 0);
    chk("rst_regs", dut_regs(), 0);
    chk("rst_ram_kept", dut_mem(), pack_m());
    for (int n = 0; n < k && !halted; n++) model_step();
    @(negedge CLK);
    #1;
    RESET = 1;
    mon_en = 1;
    for (int c = 0; c < 400 && q.size() > 0; c++) step_clk(1);
    if (q.size() != 0) begin
      chk("retire_timeout", q.size(), 0);
      q.delete();
    end
    if (halted) begin
      step_clk(12);
      chk("halt_zstate", dut.zstate, 9);
      chk("halt_pc", dut.PC, m_pc);
      chk("halt_mem", dut_mem(), pack_m());
    end
  endtask

  // Abort the next instruction before it can write anything, then confirm nothing leaked.
  task automatic abort(input int d);
    step_clk(d);
    RESET = 0;
    mon_en = 0;
    #1;
    chk("abort_regs", dut_regs(), 0);
    chk("abort_pc", dut.PC, 0);
    chk("abort_mem", dut_mem(), pack_m());
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) init_mem[i] = 8'h00;
  endtask

  initial begin
    logic [7:0] alu_ops [3];
    logic [7:0] alu_res [3];
    alu_ops = '{8'hC5, 8'hC9, 8'hCD};
    alu_res = '{8'hFD, 8'h00, 8'h07};
    step_clk(2);

    clear_mem();
    init_mem[0] = 8'h4E; init_mem[1] = 8'h5F; init_mem[2] = 8'hC1;
    init_mem[14] = 8'h02; init_mem[15] = 8'h05;
    run(3);
    chk("prog_r0", dut.register_file.registers[0], 8'h07);
    chk("prog_r1", dut.register_file.registers[1], 8'h05);
    chk("prog_pc", dut.PC, 4'd3);
    chk("prog_zstate", dut.zstate, 0);
    abort(1);

    clear_mem();
    init_mem[0] = 8'h4E; init_mem[1] = 8'h8D; init_mem[14] = 8'hA5;
    run(2);
    chk("str_mem13", dut.ram_inst.registers[13], 8'hA5);
    abort(2);

    for (int i = 0; i < 3; i++) begin
      clear_mem();
      init_mem[0] = 8'h4E; init_mem[1] = 8'h5F; init_mem[2] = alu_ops[i];
      init_mem[14] = 8'h02; init_mem[15] = 8'h05;
      run(3);
      chk("alu_r0", dut.register_file.registers[0], alu_res[i]);
      abort(1);
    end

    clear_mem();
    init_mem[0] = 8'h4E; init_mem[1] = 8'hC0; init_mem[14] = 8'h80;
    run(2);
    chk("add_wrap_r0", dut.register_file.registers[0], 8'h00);
    abort(1);

    for (int i = 0; i < 16; i++) init_mem[i] = 8'h10 | 8'(i);
    run(17);
    chk("wrap_pc", dut.PC, 4'd1);
    chk("wrap_ir", dut.IR, 8'h10);
    abort(2);

    clear_mem();
    init_mem[0] = 8'h4E; init_mem[1] = 8'h5F; init_mem[2] = 8'hC1;
    init_mem[14] = 8'h02; init_mem[15] = 8'h05;
    run(2);
    step_clk(4);
    chk("mid_alu_zstate", dut.zstate, 4);
    RESET = 0;
    mon_en = 0;
    #1;
    chk("mid_alu_r0", dut.register_file.registers[0], 8'h00);
    step_clk(2);
    chk("mid_alu_r0_held", dut.register_file.registers[0], 8'h00);
    chk("mid_alu_zstate_rst", dut.zstate, 0);

`ifdef ZEPHYR_HALT_EN
    init_mem[3] = 8'h0F;
    run(4);
    chk("halt_fixed_pc", dut.PC, 4'd4);
    chk("halt_fixed_zstate", dut.zstate, 4'd9);
    abort(1);
`endif

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) init_mem[i] = 8'($urandom);
      run($urandom_range(5, 25));
      abort($urandom_range(1, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
